// File: rtl/gray_counter.sv
// Registered up/down counter holding a binary count and its Gray equivalent in lock-step.
// Gray output is registered for clean clock-domain crossing; gray_next_o is the look-ahead value.
module gray_counter #(
    parameter int unsigned             CNTR_WIDTH = 8,
    parameter logic [CNTR_WIDTH-1:0]   RESET_BIN  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    input  logic                  dec_i,
    input  logic                  load_i,
    input  logic [CNTR_WIDTH-1:0] load_gray_i,
    output logic [CNTR_WIDTH-1:0] bin_o,
    output logic [CNTR_WIDTH-1:0] gray_o,
    output logic [CNTR_WIDTH-1:0] gray_next_o,
    output logic                  wrap_o
);

    localparam int unsigned W = CNTR_WIDTH;
    localparam logic [W-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

    function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b        = '0;
        b[W-1]   = g[W-1];
        for (int i = int'(W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;

    // Next-value selection: reset > load > inc > dec > hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (reset) begin
            bin_d = RESET_BIN;
        end else if (load_i) begin
            bin_d = gray_to_bin(load_gray_i);
        end else if (inc_i && !dec_i) begin
            bin_d  = bin_q + W'(1);
            wrap_d = &bin_q;
        end else if (dec_i && !inc_i) begin
            bin_d  = bin_q - W'(1);
            wrap_d = (bin_q == '0);
        end
        gray_d = bin_to_gray(bin_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= RESET_BIN;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_o       = bin_q;
    assign gray_o      = gray_q;
    assign wrap_o      = wrap_q;
    assign gray_next_o = gray_d;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at CNTR_WIDTH=4, with RESET_BIN=0 (u0) and RESET_BIN=5 (u5).
module tb_gray_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, inc, dec, load;
    logic [3:0] load_gray;
    logic [3:0] bin, gray, gray_nx;
    logic       wrap;

    logic       reset5, inc5, dec5, load5;
    logic [3:0] load_gray5;
    logic [3:0] bin5, gray5, gray_nx5;
    logic       wrap5;

    int vectors    = 0;
    int miscompares = 0;

    gray_counter #(.CNTR_WIDTH(4), .RESET_BIN(4'd0)) u0 (
        .clk(clk), .reset(reset), .inc_i(inc), .dec_i(dec), .load_i(load),
        .load_gray_i(load_gray), .bin_o(bin), .gray_o(gray),
        .gray_next_o(gray_nx), .wrap_o(wrap)
    );

    gray_counter #(.CNTR_WIDTH(4), .RESET_BIN(4'd5)) u5 (
        .clk(clk), .reset(reset5), .inc_i(inc5), .dec_i(dec5), .load_i(load5),
        .load_gray_i(load_gray5), .bin_o(bin5), .gray_o(gray5),
        .gray_next_o(gray_nx5), .wrap_o(wrap5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; inc = 1'b1; dec = 1'b0; load = 1'b0; load_gray = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({bin, gray, wrap} !== {4'd0, 4'b0000, 1'b0}) begin
                miscompares++;
                $display("FAIL reset cyc%0d: bin=%0d gray=%b wrap=%b, want 0/0000/0", c, bin, gray, wrap);
            end
            vectors++;
            if (gray_nx !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_gray_next cyc%0d: got %b want 0000", c, gray_nx);
            end
        end
    endtask

    task automatic test_inc_sweep();
        logic [3:0] exp_gray [17] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                      4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                      4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        logic [3:0] prev_gray;
        logic [3:0] exp_bin;
        prev_gray = gray;
        reset = 1'b0; inc = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_bin = 4'(k % 16);
            vectors++;
            if ({bin, gray, wrap} !== {exp_bin, exp_gray[k-1], (k == 16)}) begin
                miscompares++;
                $display("FAIL inc_sweep step%0d: bin=%0d gray=%b wrap=%b, want %0d/%b/%b",
                         k, bin, gray, wrap, exp_bin, exp_gray[k-1], (k == 16));
            end
            vectors++;
            if ($countones(gray ^ prev_gray) != 1) begin
                miscompares++;
                $display("FAIL inc_hamming step%0d: %b -> %b, want distance 1", k, prev_gray, gray);
            end
            prev_gray = gray;
        end
        inc = 1'b0;
    endtask

    task automatic test_dec_wrap();
        dec = 1'b1;
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd0, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_to_zero: bin=%0d gray=%b wrap=%b, want 0/0000/0", bin, gray, wrap);
        end
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd15, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL dec_wrap: bin=%0d gray=%b wrap=%b, want 15/1000/1", bin, gray, wrap);
        end
        dec = 1'b0;
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd15, 4'b1000, 1'b0}) begin
            miscompares++;
            $display("FAIL dec_idle: bin=%0d gray=%b wrap=%b, want 15/1000/0", bin, gray, wrap);
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_gray = 4'b1101; inc = 1'b1;
        #1;
        vectors++;
        if (gray_nx !== 4'b1101) begin
            miscompares++;
            $display("FAIL load_gray_next: got %b want 1101", gray_nx);
        end
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd9, 4'b1101, 1'b0}) begin
            miscompares++;
            $display("FAIL load: bin=%0d gray=%b wrap=%b, want 9/1101/0", bin, gray, wrap);
        end
        load = 1'b0;
        #1;
        vectors++;
        if (gray_nx !== 4'b1111) begin
            miscompares++;
            $display("FAIL inc_gray_next: got %b want 1111", gray_nx);
        end
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd10, 4'b1111, 1'b0}) begin
            miscompares++;
            $display("FAIL inc_after_load: bin=%0d gray=%b wrap=%b, want 10/1111/0", bin, gray, wrap);
        end
        inc = 1'b0;
    endtask

    task automatic test_inc_dec_both();
        load = 1'b1; load_gray = 4'b0100;
        tick();
        load = 1'b0; inc = 1'b1; dec = 1'b1;
        #1;
        vectors++;
        if (gray_nx !== 4'b0100) begin
            miscompares++;
            $display("FAIL both_gray_next: got %b want 0100", gray_nx);
        end
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd7, 4'b0100, 1'b0}) begin
            miscompares++;
            $display("FAIL both_hold: bin=%0d gray=%b wrap=%b, want 7/0100/0", bin, gray, wrap);
        end
        inc = 1'b0; dec = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; load_gray = 4'b1000;
        tick();
        load = 1'b0; inc = 1'b1;
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd0, 4'b0000, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_inc_wrap: bin=%0d gray=%b wrap=%b, want 0/0000/1", bin, gray, wrap);
        end
        inc = 1'b0; dec = 1'b1;
        tick();
        vectors++;
        if ({bin, gray, wrap} !== {4'd15, 4'b1000, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_dec_wrap: bin=%0d gray=%b wrap=%b, want 15/1000/1", bin, gray, wrap);
        end
        dec = 1'b0;
        tick();
        vectors++;
        if (wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: wrap=%b want 0", wrap);
        end
    endtask

    task automatic test_mid_reset();
        reset5 = 1'b1;
        tick();
        vectors++;
        if ({bin5, gray5, wrap5} !== {4'd5, 4'b0111, 1'b0}) begin
            miscompares++;
            $display("FAIL rst5_init: bin=%0d gray=%b wrap=%b, want 5/0111/0", bin5, gray5, wrap5);
        end
        reset5 = 1'b0; inc5 = 1'b1;
        repeat (7) tick();
        vectors++;
        if ({bin5, gray5, wrap5} !== {4'd12, 4'b1010, 1'b0}) begin
            miscompares++;
            $display("FAIL rst5_count: bin=%0d gray=%b wrap=%b, want 12/1010/0", bin5, gray5, wrap5);
        end
        reset5 = 1'b1; load5 = 1'b1; load_gray5 = 4'b1111;
        #1;
        vectors++;
        if (gray_nx5 !== 4'b0111) begin
            miscompares++;
            $display("FAIL rst5_gray_next: got %b want 0111", gray_nx5);
        end
        tick();
        vectors++;
        if ({bin5, gray5, wrap5} !== {4'd5, 4'b0111, 1'b0}) begin
            miscompares++;
            $display("FAIL rst5_mid: bin=%0d gray=%b wrap=%b, want 5/0111/0", bin5, gray5, wrap5);
        end
        reset5 = 1'b0; load5 = 1'b0; inc5 = 1'b0;
    endtask

    initial begin
        reset  = 1'b1; inc  = 1'b0; dec  = 1'b0; load  = 1'b0; load_gray  = 4'b0000;
        reset5 = 1'b1; inc5 = 1'b0; dec5 = 1'b0; load5 = 1'b0; load_gray5 = 4'b0000;
        test_reset();
        test_inc_sweep();
        test_dec_wrap();
        test_load();
        test_inc_dec_both();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
